// File: rtl/word_byte_splitter.sv
// word_byte_splitter: unpacks a 16-bit word into two bytes on a valid/ready
// byte stream, one byte per cycle, high byte first. Back-to-back words are
// accepted without a bubble while the low byte drains.
// Optional build macro: SPLIT_LSB_FIRST_EN -- emit the low byte first and the
// high byte second (out_last still marks the second byte; timing unchanged).
module word_byte_splitter #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned BYTE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    // Word must split into exactly two bytes
    generate
        if (WORD_W != 2 * BYTE_W) begin : g_width_check
            $error("word_byte_splitter: WORD_W must equal 2*BYTE_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HI   = 2'b01,
        ST_LO   = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_wbuf;
    logic [WORD_W-1:0]   w_wbuf_nxt;
    logic [BYTE_W-1:0]   r_out_data;
    logic [BYTE_W-1:0]   w_out_data_nxt;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic                r_out_last;
    logic                w_out_last_nxt;

    logic [BYTE_W-1:0]   w_in_first;
    logic [BYTE_W-1:0]   w_buf_first;
    logic [BYTE_W-1:0]   w_buf_second;

    // Byte ordering: pure bit slices of the word, no arithmetic
`ifdef SPLIT_LSB_FIRST_EN
    assign w_in_first   = in_data[BYTE_W-1:0];
    assign w_buf_first  = r_wbuf[BYTE_W-1:0];
    assign w_buf_second = r_wbuf[WORD_W-1 -: BYTE_W];
`else
    assign w_in_first   = in_data[WORD_W-1 -: BYTE_W];
    assign w_buf_first  = r_wbuf[WORD_W-1 -: BYTE_W];
    assign w_buf_second = r_wbuf[BYTE_W-1:0];
`endif

    // Upstream may hand over a word when empty or when the last byte leaves now
    assign in_ready  = !reset && ((r_state == ST_IDLE) ||
                                  ((r_state == ST_LO) && out_ready));
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    // State and output registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wbuf      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wbuf      <= w_wbuf_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_wbuf_nxt      = r_wbuf;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_wbuf_nxt      = in_data;
                    w_out_data_nxt  = w_in_first;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = 1'b0;
                    w_state_nxt     = ST_HI;
                end
            end
            ST_HI: begin
                if (out_ready) begin
                    w_out_data_nxt = w_buf_second;
                    w_out_last_nxt = 1'b1;
                    w_state_nxt    = ST_LO;
                end else begin
                    // Stalled: keep presenting the first byte of the stored word
                    w_out_data_nxt = w_buf_first;
                end
            end
            ST_LO: begin
                if (out_ready) begin
                    if (in_valid) begin
                        w_wbuf_nxt      = in_data;
                        w_out_data_nxt  = w_in_first;
                        w_out_valid_nxt = 1'b1;
                        w_out_last_nxt  = 1'b0;
                        w_state_nxt     = ST_HI;
                    end else begin
                        w_out_data_nxt  = '0;
                        w_out_valid_nxt = 1'b0;
                        w_out_last_nxt  = 1'b0;
                        w_state_nxt     = ST_IDLE;
                    end
                end
            end
            default: begin
                // Unreachable encoding recovers to an empty splitter
                w_out_data_nxt  = '0;
                w_out_valid_nxt = 1'b0;
                w_out_last_nxt  = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_word_byte_splitter.sv
// Testbench for word_byte_splitter: directed vector table, a queue-based
// reference model under random traffic, and a back-to-back throughput run.
module tb_word_byte_splitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Bytes accepted but not yet taken by the consumer, in emission order
    logic [7:0] q[$];

    word_byte_splitter #(.WORD_W(16), .BYTE_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic [7:0]  od;
        logic        ol;
        logic        bz;
    } vec_t;

    function automatic logic [7:0] first_b(input logic [15:0] w);
`ifdef SPLIT_LSB_FIRST_EN
        return w[7:0];
`else
        return w[15:8];
`endif
    endfunction

    function automatic logic [7:0] second_b(input logic [15:0] w);
`ifdef SPLIT_LSB_FIRST_EN
        return w[15:8];
`else
        return w[7:0];
`endif
    endfunction

    function automatic vec_t mk(input logic rst, input logic iv, input logic [15:0] d,
                                input logic ordy, input logic ir, input logic ov,
                                input logic [7:0] od, input logic ol, input logic bz);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ir = ir; v.ov = ov; v.od = od; v.ol = ol; v.bz = bz;
        return v;
    endfunction

    // Compare {in_ready, out_valid, out_last, busy, out_data}
    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got {ir,ov,last,busy,data}=%b_%b_%b_%b_%h expected %b_%b_%b_%b_%h",
                     name, cyc, got[11], got[10], got[9], got[8], got[7:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // One cycle: drive after the edge, check mid-cycle against the model, advance model
    task automatic step(input string name, input logic rst, input logic iv,
                        input logic [15:0] d, input logic ordy,
                        output logic acc_in, output logic acc_out);
        int unsigned n;
        logic        e_ir;
        logic [7:0]  e_od;
        @(posedge clk);
        #1;
        reset = rst; in_valid = iv; in_data = d; out_ready = ordy;
        @(negedge clk);
        cyc++;
        n    = q.size();
        e_ir = !rst && (n == 0 || (n == 1 && ordy));
        e_od = (n != 0) ? q[0] : 8'h00;
        chk(name, {in_ready, out_valid, out_last, busy, out_data},
                  {e_ir, (n != 0), (n == 1), (n != 0), e_od});
        acc_out = (n != 0) && ordy && !rst;
        acc_in  = iv && e_ir;
        if (rst) begin
            q.delete();
        end else begin
            if (acc_out) void'(q.pop_front());
            if (acc_in) begin
                q.push_back(first_b(d));
                q.push_back(second_b(d));
            end
        end
    endtask

    vec_t tbl[25];

    initial begin
        logic        ai, ao;
        logic        hold_v;
        logic [15:0] hold_d;
        logic        iv;
        logic [15:0] d;
        logic        rs, ordy;
        logic [15:0] words[4];
        int          idx, nbytes, first_c, last_c;

        reset = 1'b1; in_valid = 1'b1; in_data = 16'hA55A; out_ready = 1'b1;

        // reset held two cycles with in_valid high
        tbl[0]  = mk(1, 1, 16'hA55A, 1,  0, 0, 8'h00, 0, 0);
        tbl[1]  = mk(1, 1, 16'hA55A, 1,  0, 0, 8'h00, 0, 0);
        // single word A55A
        tbl[2]  = mk(0, 1, 16'hA55A, 1,  1, 0, 8'h00, 0, 0);
        tbl[3]  = mk(0, 0, 16'h0000, 1,  0, 1, first_b(16'hA55A), 0, 1);
        tbl[4]  = mk(0, 0, 16'h0000, 1,  1, 1, second_b(16'hA55A), 1, 1);
        tbl[5]  = mk(0, 0, 16'h0000, 1,  1, 0, 8'h00, 0, 0);
        // 1234 then BEEF back-to-back
        tbl[6]  = mk(0, 1, 16'h1234, 1,  1, 0, 8'h00, 0, 0);
        tbl[7]  = mk(0, 1, 16'hBEEF, 1,  0, 1, first_b(16'h1234), 0, 1);
        tbl[8]  = mk(0, 1, 16'hBEEF, 1,  1, 1, second_b(16'h1234), 1, 1);
        tbl[9]  = mk(0, 0, 16'h0000, 1,  0, 1, first_b(16'hBEEF), 0, 1);
        tbl[10] = mk(0, 0, 16'h0000, 1,  1, 1, second_b(16'hBEEF), 1, 1);
        tbl[11] = mk(0, 0, 16'h0000, 1,  1, 0, 8'h00, 0, 0);
        // C3F0 with consumer stalled three cycles on the first byte
        tbl[12] = mk(0, 1, 16'hC3F0, 0,  1, 0, 8'h00, 0, 0);
        tbl[13] = mk(0, 0, 16'h0000, 0,  0, 1, first_b(16'hC3F0), 0, 1);
        tbl[14] = mk(0, 0, 16'h0000, 0,  0, 1, first_b(16'hC3F0), 0, 1);
        tbl[15] = mk(0, 0, 16'h0000, 0,  0, 1, first_b(16'hC3F0), 0, 1);
        tbl[16] = mk(0, 0, 16'h0000, 1,  0, 1, first_b(16'hC3F0), 0, 1);
        tbl[17] = mk(0, 0, 16'h0000, 0,  0, 1, second_b(16'hC3F0), 1, 1);
        tbl[18] = mk(0, 0, 16'h0000, 1,  1, 1, second_b(16'hC3F0), 1, 1);
        tbl[19] = mk(0, 0, 16'h0000, 1,  1, 0, 8'h00, 0, 0);
        // reset while the second byte is stalled: byte dropped
        tbl[20] = mk(0, 1, 16'hA55A, 1,  1, 0, 8'h00, 0, 0);
        tbl[21] = mk(0, 0, 16'h0000, 1,  0, 1, first_b(16'hA55A), 0, 1);
        tbl[22] = mk(0, 0, 16'h0000, 0,  0, 1, second_b(16'hA55A), 1, 1);
        tbl[23] = mk(1, 0, 16'h0000, 0,  0, 1, second_b(16'hA55A), 1, 1);
        tbl[24] = mk(0, 0, 16'h0000, 1,  1, 0, 8'h00, 0, 0);

        // Directed table
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            reset = tbl[i].rst; in_valid = tbl[i].iv;
            in_data = tbl[i].d; out_ready = tbl[i].ordy;
            @(negedge clk);
            cyc++;
            chk($sformatf("vec%0d", i), {in_ready, out_valid, out_last, busy, out_data},
                {tbl[i].ir, tbl[i].ov, tbl[i].ol, tbl[i].bz, tbl[i].od});
        end
        q.delete();

        // Random traffic; upstream holds a refused word until it is accepted
        hold_v = 1'b0;
        hold_d = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            rs = ($urandom_range(0, 99) == 0);
            if (hold_v) begin
                iv = 1'b1;
                d  = hold_d;
            end else begin
                iv = ($urandom_range(0, 3) != 0);
                d  = 16'($urandom);
            end
            ordy = ($urandom_range(0, 3) != 0);
            step("rand", rs, iv, d, ordy, ai, ao);
            hold_v = iv && !ai;
            hold_d = d;
        end

        // Drain any word left over from the random phase
        for (int k = 0; k < 4 && q.size() != 0; k++)
            step("drain", 1'b0, 1'b0, 16'h0000, 1'b1, ai, ao);

        // Four words back-to-back with the consumer always ready
        words[0] = 16'h0102; words[1] = 16'h0304; words[2] = 16'hA0B0; words[3] = 16'hFFEE;
        idx = 0; nbytes = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 60 && nbytes < 8; c++) begin
            d = (idx < 4) ? words[idx] : 16'h0000;
            step("burst", 1'b0, (idx < 4), d, 1'b1, ai, ao);
            if (ai) begin
                if (first_c < 0) first_c = c;
                idx++;
            end
            if (ao) begin
                nbytes++;
                if (nbytes == 8) last_c = c;
            end
        end
        n_cmp++;
        if (nbytes != 8 || first_c < 0 || (last_c - first_c + 1) != 9) begin
            n_err++;
            $display("FAIL throughput: got bytes=%0d span=%0d cycles, expected bytes=8 span=9",
                     nbytes, last_c - first_c + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
